// File: rtl/am_mag_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one iterative sqrt engine across NCH I/Q channels: envelope = floor(sqrt(I^2+Q^2)).
// Latency 3+RW/2 cycles from accept to out_valid; one request in flight, req_ready only in IDLE, result held until out_ready.
module am_mag_sched #(
    parameter int NCH = 2,
    parameter int DW  = 8,
    parameter int RW  = 2*DW,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req_valid,
    output logic [NCH-1:0]      req_ready,
    input  logic [NCH*DW-1:0]   req_i,
    input  logic [NCH*DW-1:0]   req_q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_ch,
    output logic [DW-1:0]       out_mag,
    output logic                sq_start,
    output logic [RW-1:0]       sq_rad,
    input  logic                sq_busy,
    input  logic                sq_valid,
    input  logic [RW-1:0]       sq_root
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQUARE,
        ST_START,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        rr_ptr_q;
    logic [CW-1:0]        rr_ptr_d;
    logic [CW-1:0]        tag_q;
    logic signed [DW-1:0] i_q;
    logic signed [DW-1:0] q_q;
    logic [RW-1:0]        sq_rad_q;
    logic                 sq_start_q;
    logic                 out_valid_q;
    logic [CW-1:0]        out_ch_q;
    logic [DW-1:0]        out_mag_q;

    logic                 found;
    logic [CW-1:0]        grant;
    logic [CW:0]          cand_w;
    logic [CW-1:0]        cand;
    logic signed [RW-1:0] i_ext;
    logic signed [RW-1:0] q_ext;
    logic signed [RW-1:0] i_sq;
    logic signed [RW-1:0] q_sq;
    logic [RW-1:0]        rad_d;
    logic                 done;
    logic                 unused_root_hi;

    // Search upward from rr_ptr with wrap; first requester wins.
    always_comb begin
        found  = 1'b0;
        grant  = '0;
        cand_w = '0;
        cand   = '0;
        for (int k = 0; k < NCH; k++) begin
            cand_w = {1'b0, rr_ptr_q} + (CW+1)'(k);
            if (cand_w >= (CW+1)'(NCH)) begin
                cand_w = cand_w - (CW+1)'(NCH);
            end
            cand = cand_w[CW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign rr_ptr_d  = (grant == CW'(NCH-1)) ? '0 : grant + CW'(1);
    assign req_ready = (state_q == ST_IDLE && found && !rst) ? (NCH'(1) << grant) : '0;

    // Each square is at most 2^(2DW-2), so the unsigned sum cannot overflow RW bits.
    assign i_ext = RW'(i_q);
    assign q_ext = RW'(q_q);
    assign i_sq  = i_ext * i_ext;
    assign q_sq  = q_ext * q_ext;
    assign rad_d = $unsigned(i_sq) + $unsigned(q_sq);

    assign done           = sq_valid && !sq_busy;
    assign unused_root_hi = ^sq_root[RW-1:DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            tag_q       <= '0;
            i_q         <= '0;
            q_q         <= '0;
            sq_rad_q    <= '0;
            sq_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_mag_q   <= '0;
        end else begin
            sq_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        i_q      <= req_i[grant*DW +: DW];
                        q_q      <= req_q[grant*DW +: DW];
                        tag_q    <= grant;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_SQUARE;
                    end
                end
                ST_SQUARE: begin
                    sq_rad_q   <= rad_d;
                    sq_start_q <= 1'b1;
                    state_q    <= ST_START;
                end
                // Engine still shows the previous result here, so completion is only looked at in WAIT.
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        out_mag_q   <= sq_root[DW-1:0];
                        out_ch_q    <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sq_start  = sq_start_q;
    assign sq_rad    = sq_rad_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_am_mag_sched.sv
`timescale 1ns/1ps
// Bench for am_mag_sched: sqrt engine stand-in, transaction-level reference model, directed and random stimulus.
module tb_am_mag_sched;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int RW  = 16;
    localparam int CW  = 1;
    localparam int LAT = 3 + RW/2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH*DW-1:0] req_i = '0;
    logic [NCH*DW-1:0] req_q = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CW-1:0]     out_ch;
    logic [DW-1:0]     out_mag;
    logic              sq_start;
    logic [RW-1:0]     sq_rad;
    logic              sq_busy = 1'b0;
    logic              sq_valid = 1'b0;
    logic [RW-1:0]     sq_root = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    am_mag_sched #(.NCH(NCH), .DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_i(req_i), .req_q(req_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_mag(out_mag),
        .sq_start(sq_start), .sq_rad(sq_rad),
        .sq_busy(sq_busy), .sq_valid(sq_valid), .sq_root(sq_root)
    );

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int samp(input logic [NCH*DW-1:0] bus, input int ch);
        logic signed [DW-1:0] v;
        v = bus[ch*DW +: DW];
        return int'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Engine stand-in: result valid RW/2 cycles after the start-pulse cycle, not reset by rst.
    int            eng_cnt = 0;
    logic [RW-1:0] eng_rad = '0;
    always @(posedge clk) begin
        if (sq_start) begin
            sq_busy  <= 1'b1;
            sq_valid <= 1'b0;
            eng_cnt  <= RW/2 - 1;
            eng_rad  <= sq_rad;
        end else if (sq_busy) begin
            if (eng_cnt == 1) begin
                sq_busy  <= 1'b0;
                sq_valid <= 1'b1;
                sq_root  <= RW'(isqrt(int'(eng_rad)));
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // Reference model: one job in flight, fixed latency, round-robin pointer.
    bit             mon_en = 1'b0;
    bit             m_busy = 1'b0;
    bit             m_out  = 1'b0;
    int             m_cnt = 0, m_rr = 0, m_tag = 0, m_prad = 0, m_pmag = 0;
    int             m_rad = 0, m_och = 0, m_omag = 0;
    int             g_total = 0, o_total = 0;
    int             g_per [NCH];
    int             wait_cnt [NCH];
    logic [NCH-1:0] hs = '0;
    int             gq[$];
    int             oq[$];
    int             omq[$];
    bit             e_found;
    int             e_g;
    logic [NCH-1:0] e_rdy;
    bit             fair_ok;

    initial begin
        for (int k = 0; k < NCH; k++) begin
            g_per[k]    = 0;
            wait_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        e_found = 1'b0;
        e_g     = 0;
        for (int k = 0; k < NCH; k++) begin
            if (!e_found && req_valid[(m_rr + k) % NCH]) begin
                e_found = 1'b1;
                e_g     = (m_rr + k) % NCH;
            end
        end
        e_rdy = '0;
        if (!m_busy && !rst && e_found) e_rdy[e_g] = 1'b1;
        if (mon_en) begin
            chk("req_ready", req_ready, e_rdy);
            chk("sq_start", sq_start, (m_busy && !m_out && m_cnt == 2));
            chk("sq_rad", sq_rad, m_rad);
            chk("out_valid", out_valid, m_out);
            chk("out_ch", out_ch, m_och);
            chk("out_mag", out_mag, m_omag);
        end
        hs = req_valid & req_ready;
        if (rst) begin
            m_busy = 1'b0; m_out = 1'b0; m_cnt = 0; m_rr = 0;
            m_rad = 0; m_och = 0; m_omag = 0;
            for (int k = 0; k < NCH; k++) wait_cnt[k] = 0;
        end else if (m_busy) begin
            if (m_out) begin
                if (out_ready) begin
                    m_out  = 1'b0;
                    m_busy = 1'b0;
                    oq.push_back(m_och);
                    omq.push_back(m_omag);
                    o_total++;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 2) m_rad = m_prad;
                if (m_cnt == LAT) begin
                    m_out  = 1'b1;
                    m_och  = m_tag;
                    m_omag = m_pmag;
                end
            end
        end else if (e_found) begin
            m_busy = 1'b1;
            m_cnt  = 1;
            m_tag  = e_g;
            m_prad = samp(req_i, e_g) * samp(req_i, e_g) + samp(req_q, e_g) * samp(req_q, e_g);
            m_pmag = isqrt(m_prad);
            m_rr   = (e_g + 1) % NCH;
            gq.push_back(e_g);
            g_total++;
            g_per[e_g]++;
            for (int k = 0; k < NCH; k++) begin
                if (k != e_g && req_valid[k]) begin
                    wait_cnt[k]++;
                    fair_ok = (wait_cnt[k] <= NCH - 1);
                    chk("fairness", fair_ok, 1);
                end else begin
                    wait_cnt[k] = 0;
                end
            end
        end
    end

    task automatic set_req(input int ch, input int iv, input int qv);
        req_valid[ch]          = 1'b1;
        req_i[ch*DW +: DW]     = DW'(iv);
        req_q[ch*DW +: DW]     = DW'(qv);
    endtask

    task automatic wait_accept(input int ch);
        int got = 0;
        for (int n = 0; n < 50 && got == 0; n++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1;
        end
        chk("accept", got, 1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300 && m_busy; n++) @(negedge clk);
        chk("drain", m_busy, 0);
    endtask

    task automatic do_req(input int ch, input int iv, input int qv, input int exp_rad, input int exp_mag);
        int lat = 0, starts = 0, rad_seen = -1, got = 0;
        @(posedge clk); #1;
        set_req(ch, iv, qv);
        wait_accept(ch);
        @(posedge clk); #1;
        req_valid[ch] = 1'b0;
        while (lat < 100 && got == 0) begin
            @(negedge clk);
            lat++;
            if (sq_start) begin
                starts++;
                rad_seen = int'(sq_rad);
            end
            if (out_valid) got = 1;
        end
        chk("latency", lat, LAT);
        chk("start_pulses", starts, 1);
        chk("lit_rad", rad_seen, exp_rad);
        chk("lit_mag", out_mag, exp_mag);
        chk("lit_ch", out_ch, ch);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, seen, g0, o0, p0, p1, lim;
        int alt_g [4];
        int alt_m [4];
        alt_g = '{0, 1, 0, 1};
        alt_m = '{5, 13, 5, 13};

        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_mag", out_mag, 0);
        chk("rst_sq_start", sq_start, 0);
        chk("rst_sq_rad", sq_rad, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1 rst = 1'b0;

        do_req(0, 3, 4, 25, 5);
        do_req(1, -128, -128, 32768, 181);
        do_req(0, 127, 0, 16129, 127);
        do_req(1, 0, 0, 0, 0);

        // Both channels held valid from rr_ptr = 0.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        gq.delete(); oq.delete(); omq.delete();
        set_req(0, 3, 4);
        set_req(1, 5, 12);
        for (int n = 0; n < 200 && gq.size() < 4; n++) @(negedge clk);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();
        chk("alt_grants", gq.size(), 4);
        chk("alt_outs", oq.size(), 4);
        lim = (oq.size() < 4) ? oq.size() : 4;
        for (int i = 0; i < lim; i++) begin
            chk("alt_grant_ch", gq[i], alt_g[i]);
            chk("alt_out_ch", oq[i], alt_g[i]);
            chk("alt_out_mag", omq[i], alt_m[i]);
        end

        // Output stall with another channel waiting.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_req(0, 6, 8);
        wait_accept(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 1, 1);
        got = 0;
        for (int n = 0; n < 100 && got == 0; n++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        chk("stall_seen", got, 1);
        for (int n = 0; n < 20; n++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_mag", out_mag, 10);
            chk("stall_ch", out_ch, 0);
            chk("stall_ready", req_ready, 0);
            chk("stall_start", sq_start, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("pre_xfer_valid", out_valid, 1);
        @(negedge clk);
        chk("post_xfer_valid", out_valid, 0);
        chk("next_grant", req_ready, 2'b10);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        // Reset pulsed while waiting on the engine.
        @(posedge clk); #1;
        set_req(1, 10, 0);
        wait_accept(1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_ch", out_ch, 0);
        chk("abort_out_mag", out_mag, 0);
        chk("abort_sq_rad", sq_rad, 0);
        chk("abort_sq_start", sq_start, 0);
        chk("abort_req_ready", req_ready, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_output", seen, 0);
        do_req(0, 3, 4, 25, 5);

        // Random traffic on both channels.
        g0 = g_total; o0 = o_total; p0 = g_per[0]; p1 = g_per[1];
        for (int cyc = 0; cyc < 40000 && (g_total - g0) < 1000; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NCH; k++) begin
                if (hs[k]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(k, int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128);
                    else
                        req_valid[k] = 1'b0;
                end else if (!req_valid[k] && $urandom_range(3, 0) == 0) begin
                    set_req(k, int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128);
                end
            end
            out_ready = ($urandom_range(3, 0) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        out_ready = 1'b1;
        wait_idle();
        chk("rand_grants", ((g_total - g0) >= 1000), 1);
        chk("rand_xfers", o_total - o0, g_total - g0);
        chk("ch0_served", ((g_per[0] - p0) > 0), 1);
        chk("ch1_served", ((g_per[1] - p1) > 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_mag_sched.md
Name: am_mag_sched

Overview:
- Round-robin scheduler that shares one iterative integer square-root engine between NCH I/Q requesters in the AM demodulator.
- Per channel it computes the envelope |x| = floor(sqrt(I² + Q²)).
- For the granted request it latches the operands, forms the I²+Q² radicand, launches the external sqrt engine, waits for completion and returns the root tagged with the channel index.
- It sits between the per-channel decimated I/Q streams and the envelope/audio path.

Parameters:
- NCH, 2, number of requesting channels (≥2).
- DW, 8, signed I/Q sample width; also the magnitude output width.
- RW, 2*DW, radicand width driven to the sqrt engine; must be even and equal to 2*DW.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel request valid.
- req_ready  out  NCH  per-channel accept, one-hot or zero.
- req_i  in  NCH*DW  packed signed I samples; channel k occupies bits [k*DW +: DW].
- req_q  in  NCH*DW  packed signed Q samples, same packing as req_i.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_ch  out  max(1,$clog2(NCH))  channel tag of the result.
- out_mag  out  DW  unsigned magnitude.
- sq_start  out  1  one-cycle start pulse to the sqrt engine.
- sq_rad  out  RW  radicand, held stable from start until done.
- sq_busy  in  1  engine busy.
- sq_valid  in  1  engine result valid; stays high after completion until the next start.
- sq_root  in  RW  engine root.

Behaviour:
- Reset values: state=IDLE, req_ready=0, out_valid=0, out_ch=0, out_mag=0, sq_start=0, sq_rad=0, rr_ptr=0.
- IDLE:
  - Arbitrate req_valid round-robin, searching from rr_ptr upward with wrap.
  - If a channel g is found: req_ready[g]=1 combinationally in this cycle (handshake completes), I/Q of g latched, tag=g, rr_ptr <= (g+1) mod NCH, next state SQUARE.
  - If no request: stay in IDLE, no ready asserted.
- SQUARE:
  - sq_rad <= I*I + Q*Q, using signed multiplies and an unsigned RW-bit sum. The maximum, 2^(2DW-1), fits without overflow.
  - Next state START.
- START: sq_start=1 for exactly this cycle; next state WAIT.
- WAIT:
  - Stay until sq_valid=1 && sq_busy=0.
  - sq_valid is ignored in the START cycle because the engine still shows the previous result then.
  - On completion: out_mag <= sq_root[DW-1:0] (the upper bits are guaranteed zero), out_ch <= tag, out_valid <= 1, next state OUT.
- OUT:
  - out_valid held with stable data until out_ready=1.
  - On the transfer cycle: out_valid <= 0, next state IDLE.
- Latency from request accept to out_valid is 3 + RW/2 cycles: SQUARE 1, START 1, engine RW/2, registering 1. The next grant is possible in the cycle after the output transfer.
- Only one request is in flight; req_ready is 0 in every state except IDLE.
- sq_rad is held constant from SQUARE through WAIT.
- Fairness: a channel holding req_valid is served within NCH grants.
- Simultaneous requests: the lowest index at or above rr_ptr wins.
- rst asserted mid-operation, including WAIT:
  - All state returns to reset values and any in-flight result is discarded.
  - The engine may still complete; its stale sq_valid is ignored because WAIT is only entered after a fresh start.
- out_ready high while out_valid is low has no effect.

Test Plan:
- DW=8. Ch0 request I=3, Q=4 -> sq_rad=25, one sq_start pulse, out_mag=5, out_ch=0, out_valid after 3+8 cycles.
- Ch1 request I=-128, Q=-128 -> sq_rad=32768, out_mag=181, out_ch=1. Also I=127, Q=0 -> 127; I=0, Q=0 -> 0.
- Both channels hold req_valid continuously with rr_ptr=0 -> grants alternate 0,1,0,1; each req_ready is a single cycle; out_ch sequence matches.
- out_ready held low 20 cycles after out_valid -> out_mag/out_ch stable, no new req_ready, no sq_start. Release -> one transfer, then the next grant.
- rst pulsed for one cycle mid-WAIT -> all outputs at reset values next cycle, no out_valid for the aborted request. A new request afterwards yields the correct result.
- Random I/Q on both channels for 1000 requests -> every out_mag equals floor(sqrt(I²+Q²)) from the reference model, tags correct, and no channel starves.
